// File: rtl/mdu_ctrl.sv
// Iterative RV64M multiply/divide unit: one bit per cycle, with early exits for divide-by-zero and signed overflow.
// Optional MDU_FAST_MUL_EN: multiplies finish in a single combinational step.
module mdu_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  DivSel,
   input  logic        Div32,
   input  logic [63:0] src1,
   input  logic [63:0] src2,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] result,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state_reg, state_next;
   logic [6:0]  cnt_reg;
   logic [2:0]  op_reg;
   logic        w_reg, neg_reg;
   logic [63:0] opa_reg, hi_reg, lo_reg, result_reg;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // sel 00 selects the low product half (mul); any other encoding selects the high half.
   function automatic logic [63:0] mul_fix(input logic [127:0] prod, input logic neg,
                                           input logic [1:0] sel, input logic w);
      logic [127:0] p;
      logic [63:0]  r;
      p = neg ? -prod : prod;
      if (w)               r = sext32(p[31:0]);
      else if (sel == 2'b00) r = p[63:0];
      else                 r = p[127:64];
      return r;
   endfunction

   function automatic logic [63:0] div_fix(input logic [63:0] rem_mag, input logic [63:0] quo_mag,
                                           input logic neg, input logic rem, input logic w);
      logic [63:0] x, v;
      x = rem ? rem_mag : quo_mag;
      v = w ? {32'd0, x[31:0]} : x;
      v = neg ? -v : v;
      return w ? sext32(v[31:0]) : v;
   endfunction

   // Operand decode for the request currently on the inputs
   logic        accept, is_div, use_s1, use_s2, neg1, neg2, neg_res;
   logic        div_zero, ovf, special, fast_mul;
   logic [63:0] x1, x2, mag1, mag2, dividend_w, special_res, fast_res;

   always_comb begin
      is_div   = DivSel[2];
      use_s1   = (!Div32 && (DivSel == 3'b001 || DivSel == 3'b010)) || DivSel == 3'b100 || DivSel == 3'b110;
      use_s2   = (!Div32 && DivSel == 3'b001) || DivSel == 3'b100 || DivSel == 3'b110;
      x1       = Div32 ? (use_s1 ? sext32(src1[31:0]) : {32'd0, src1[31:0]}) : src1;
      x2       = Div32 ? (use_s2 ? sext32(src2[31:0]) : {32'd0, src2[31:0]}) : src2;
      neg1     = use_s1 && x1[63];
      neg2     = use_s2 && x2[63];
      mag1     = neg1 ? -x1 : x1;
      mag2     = neg2 ? -x2 : x2;
      neg_res  = (is_div && DivSel[1]) ? neg1 : (neg1 ^ neg2);
      div_zero = is_div && (Div32 ? (src2[31:0] == 32'd0) : (src2 == 64'd0));
      ovf      = is_div && !DivSel[0] &&
                 (Div32 ? (src1[31:0] == 32'h8000_0000 && src2[31:0] == 32'hFFFF_FFFF)
                        : (src1 == 64'h8000_0000_0000_0000 && src2 == 64'hFFFF_FFFF_FFFF_FFFF));
      special  = div_zero || ovf;
      dividend_w  = Div32 ? sext32(src1[31:0]) : src1;
      if (div_zero) special_res = DivSel[1] ? dividend_w : 64'hFFFF_FFFF_FFFF_FFFF;
      else          special_res = DivSel[1] ? 64'd0 : dividend_w;
   end

`ifdef MDU_FAST_MUL_EN
   logic [127:0] prod_full;
   assign prod_full = {64'd0, mag1} * {64'd0, mag2};
   assign fast_mul  = !DivSel[2];
   assign fast_res  = mul_fix(prod_full, neg_res, DivSel[1:0], Div32);
`else
   assign fast_mul  = 1'b0;
   assign fast_res  = 64'd0;
`endif

   assign accept    = in_valid && (state_reg == IDLE) && !flush;
   assign in_ready  = (state_reg == IDLE);
   assign busy      = (state_reg != IDLE);
   assign out_valid = (state_reg == DONE) && !flush;
   assign result    = out_valid ? result_reg : 64'd0;

   // One iteration: multiply adds into the high half and shifts right; divide shifts left and restores.
   logic [64:0] mul_sum, div_rs, div_diff;
   logic [63:0] hi_step, lo_step, calc_res;
   always_comb begin
      mul_sum  = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opa_reg} : 65'd0);
      div_rs   = {hi_reg, (w_reg ? lo_reg[31] : lo_reg[63])};
      div_diff = div_rs - {1'b0, opa_reg};
      if (op_reg[2]) begin
         hi_step = div_diff[64] ? div_rs[63:0] : div_diff[63:0];
         lo_step = {lo_reg[62:0], ~div_diff[64]};
         calc_res = div_fix(hi_step, lo_step, neg_reg, op_reg[1], w_reg);
      end else begin
         hi_step = mul_sum[64:1];
         lo_step = {mul_sum[0], lo_reg[63:1]};
         calc_res = mul_fix(w_reg ? {64'd0, hi_step[31:0], lo_step[63:32]} : {hi_step, lo_step},
                            neg_reg, op_reg[1:0], w_reg);
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = (special || fast_mul) ? DONE : CALC;
         CALC:    if (cnt_reg == 7'd1) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= 7'd0;
         op_reg     <= 3'd0;
         w_reg      <= 1'b0;
         neg_reg    <= 1'b0;
         opa_reg    <= 64'd0;
         hi_reg     <= 64'd0;
         lo_reg     <= 64'd0;
         result_reg <= 64'd0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            op_reg  <= DivSel;
            w_reg   <= Div32;
            neg_reg <= neg_res;
            cnt_reg <= Div32 ? 7'd32 : 7'd64;
            opa_reg <= is_div ? mag2 : mag1;
            hi_reg  <= 64'd0;
            lo_reg  <= is_div ? mag1 : mag2;
            if (special)       result_reg <= special_res;
            else if (fast_mul) result_reg <= fast_res;
         end else if (state_reg == CALC) begin
            hi_reg  <= hi_step;
            lo_reg  <= lo_step;
            cnt_reg <= cnt_reg - 7'd1;
            if (cnt_reg == 7'd1) result_reg <= calc_res;
         end
      end
   end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1: operation request from execute stage.
REQ-004 SHALL have port in_ready, output, 1: high only in IDLE; request accepted when in_valid && in_ready && !flush.
REQ-005 SHALL have port DivSel, input, 3: funct3 encoding: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-006 SHALL have port Div32, input, 1: W-variant (32-bit operation).
REQ-007 SHALL have ports src1 and src2, input, 64 each: rs1 and rs2 operands.
REQ-008 SHALL have port flush, input, 1: abort any operation.
REQ-009 SHALL have port out_valid, output, 1: result available.
REQ-010 SHALL have port out_ready, input, 1: consumer takes result.
REQ-011 SHALL have port result, output, 64: final value, held stable while out_valid && !out_ready.
REQ-012 SHALL have port busy, output, 1: high in any state except IDLE; drives pipeline stall.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE, plus IDLE -> DONE for special cases.
REQ-014 SHALL latch DivSel, Div32 and the operands on accept.
REQ-015 Signed ops SHALL convert operands to magnitudes, run unsigned, and fix sign at the end.
- Product sign: src1 sign XOR src2 sign (mulhsu: src1 sign only).
- Quotient sign: XOR of signs; remainder sign: dividend sign.
REQ-016 Div32 SHALL use src[31:0], sign- or zero-extended per op; 32-bit result is sign-extended to 64 bits; Div32 with DivSel 001-011 SHALL behave as mulw.
REQ-017 CALC SHALL process one bit per cycle with a down-counter loaded with N = 64, or 32 when Div32.
- Multiply: shift-add into 128-bit accumulator; mul returns low 64 bits, mulh* returns high 64 bits.
- Divide: restoring shift-subtract.
REQ-018 Accept at cycle T SHALL give out_valid high from cycle T+N+1.
REQ-019 Divide by zero SHALL skip CALC: out_valid at T+1.
- Quotient = all ones (0xFFFF_FFFF_FFFF_FFFF).
- Remainder = dividend, sign-extended for W.
REQ-020 Signed overflow (most-negative / -1, at 64- or 32-bit width) SHALL skip CALC: quotient = dividend, remainder = 0, out_valid at T+1.
REQ-021 In DONE, out_valid && out_ready SHALL return to IDLE next cycle; in_ready is not asserted in the same cycle (no back-to-back accept).
REQ-022 flush SHALL, in any state, force IDLE next cycle with out_valid low and no result delivered; flush with in_valid in IDLE accepts nothing.
REQ-023 result SHALL be 0 whenever out_valid is low.

Reset
REQ-024 rst SHALL force IDLE, counter 0, accumulators 0, out_valid 0, busy 0, result 0, in_ready 1 from the following cycle.
REQ-025 rst mid-operation SHALL discard the operation identically to flush; rst has priority over flush and in_valid.

Configuration
REQ-026 Macro MDU_FAST_MUL_EN defined: multiply ops (DivSel[2]=0) SHALL compute in one combinational step and go IDLE -> DONE, out_valid at T+1; divide timing unchanged.
REQ-027 Macro MDU_FAST_MUL_EN undefined: multiply SHALL use iterative CALC per REQ-017/018; results SHALL be bit-identical in both builds.

Verification
REQ-028 mul src1=7, src2=-3 (0xFFFF_FFFF_FFFF_FFFD) -> result 0xFFFF_FFFF_FFFF_FFEB, out_valid at T+65 (T+1 with MDU_FAST_MUL_EN).
REQ-029 div src1=-20, src2=3 -> result 0xFFFF_FFFF_FFFF_FFFA (-6), out_valid at T+65; rem of the same operands -> 0xFFFF_FFFF_FFFF_FFFE (-2).
REQ-030 divuw src1=0x1_0000_0007, src2=2 -> result 3, out_valid at T+33; remw src1=0x8000_0000, src2=-1 -> result 0 at T+1.
REQ-031 divu src2=0, src1=0x1234 -> result 0xFFFF_FFFF_FFFF_FFFF at T+1; remu with the same operands -> 0x1234.
REQ-032 mulhu src1=src2=0xFFFF_FFFF_FFFF_FFFF -> result 0xFFFF_FFFF_FFFF_FFFE; hold out_ready low 5 cycles -> result stable, busy high throughout.
REQ-033 Start div, assert flush at T+10 -> IDLE at T+11, out_valid never high, in_ready 1; repeat with rst -> same response.
